jt51_op_wr_sched: RTL and testbench

- Schedules CPU writes to the operator parameter registers (address 0x40–0xFF) into the 32-slot circulating operator CSR shift register.
- Buffers writes in a small FIFO.
- Decodes each address into a field pair and a target slot, then waits until that slot reaches the shift-register input.
- Pulses the matching up_*_op strobes with the data for exactly one cen cycle.
- Sits between the jt51 MMR write decoder and the operator CSR.

---
 rtl/jt51_op_wr_sched_if.sv | 10 +
 rtl/jt51_op_wr_sched.sv | 186 ++++++++++++++++++
 tb/tb_jt51_op_wr_sched.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/jt51_op_wr_sched_if.sv
// Write handshake between the jt51 MMR write decoder and the operator write scheduler.
interface jt51_op_wr_sched_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/jt51_op_wr_sched.sv
// Queues CPU writes to operator registers 0x40-0xFF and strobes them into the
// circulating operator CSR when the target slot comes round. Optional counters: JT51_OPWR_STATS_EN.
module jt51_op_wr_sched #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SLOT_OFS = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 sync,
  jt51_op_wr_sched_if.slave    wr,
  output logic [7:0]           din,
  output logic                 up_dt1_op,
  output logic                 up_mul_op,
  output logic                 up_tl_op,
  output logic                 up_ks_op,
  output logic                 up_amsen_op,
  output logic                 up_dt2_op,
  output logic                 up_d1l_op,
  output logic                 up_ar_op,
  output logic                 up_d1r_op,
  output logic                 up_d2r_op,
  output logic                 up_rr_op,
  output logic                 busy,
  output logic                 bad_addr
`ifdef JT51_OPWR_STATS_EN
  ,
  output logic [15:0]          wr_cnt,
  output logic [7:0]           drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [4:0]  OFS = 5'(SLOT_OFS % 32);

  // Bit positions inside the registered strobe vector
  localparam int B_DT1 = 10, B_MUL = 9, B_TL = 8, B_KS = 7, B_AMSEN = 6, B_DT2 = 5;
  localparam int B_D1L = 4,  B_AR  = 3, B_D1R = 2, B_D2R = 1, B_RR = 0;

  typedef enum logic [1:0] { ST_IDLE, ST_WAIT, ST_APPLY } state_t;

  typedef struct packed {
    logic [2:0] grp;
    logic [4:0] slot;
    logic [7:0] data;
  } entry_t;

  function automatic logic [10:0] decode(input logic [2:0] grp);
    logic [10:0] v;
    v = '0;
    case (grp)
      3'd2: begin v[B_DT1]   = 1'b1; v[B_MUL] = 1'b1; end
      3'd3: begin v[B_TL]    = 1'b1;                  end
      3'd4: begin v[B_KS]    = 1'b1; v[B_AR]  = 1'b1; end
      3'd5: begin v[B_AMSEN] = 1'b1; v[B_D1R] = 1'b1; end
      3'd6: begin v[B_DT2]   = 1'b1; v[B_D2R] = 1'b1; end
      3'd7: begin v[B_D1L]   = 1'b1; v[B_RR]  = 1'b1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, sel_ptr;
  logic [AW:0]     count;
  logic [4:0]      slot, slot_nx;
  state_t          state, state_nx;
  logic [10:0]     up_q;
  logic            push, pop, load, low_addr, empty;
  entry_t          cand;

  assign empty       = (count == '0);
  assign wr.wr_ready = (count != (AW+1)'(DEPTH));
  assign low_addr    = (wr.wr_addr[7:6] == 2'b00);
  assign push        = wr.wr_valid & wr.wr_ready & ~low_addr;
  assign slot_nx     = sync ? 5'd0 : slot + 5'd1;
  assign busy        = ~empty | (state == ST_APPLY);

  // Entry storage: holds only queued data, validity comes from the pointers.
  // NOTE: the FIFO array is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{grp: wr.wr_addr[7:5], slot: wr.wr_addr[4:0] + OFS, data: wr.wr_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      slot     <= '0;
      state    <= ST_IDLE;
      bad_addr <= 1'b0;
    end else begin
      state    <= state_nx;
      bad_addr <= wr.wr_valid & wr.wr_ready & low_addr;
      if (cen)  slot   <= slot_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // During APPLY the candidate is the entry behind the head, so a write for the
  // following slot can be loaded on the same edge that retires the current one.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    pop      = 1'b0;
    sel_ptr  = rd_ptr;
    case (state)
      ST_IDLE, ST_WAIT: begin
        if (cen && !empty) begin
          if (mem[sel_ptr].slot == slot_nx) begin
            load     = 1'b1;
            state_nx = ST_APPLY;
          end else begin
            state_nx = ST_WAIT;
          end
        end else if (empty) begin
          state_nx = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (cen) begin
          pop = 1'b1;
          if (count > (AW+1)'(1)) begin
            sel_ptr = rd_ptr + 1'b1;
            if (mem[sel_ptr].slot == slot_nx) begin
              load     = 1'b1;
              state_nx = ST_APPLY;
            end else begin
              state_nx = ST_WAIT;
            end
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    cand = mem[sel_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q <= '0;
      din  <= '0;
    end else if (load) begin
      up_q <= decode(cand.grp);
      din  <= cand.data;
    end else if (pop) begin
      up_q <= '0;
    end
  end

`ifdef JT51_OPWR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop) wr_cnt <= wr_cnt + 16'd1;
      if (bad_addr && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  assign up_dt1_op   = up_q[B_DT1];
  assign up_mul_op   = up_q[B_MUL];
  assign up_tl_op    = up_q[B_TL];
  assign up_ks_op    = up_q[B_KS];
  assign up_amsen_op = up_q[B_AMSEN];
  assign up_dt2_op   = up_q[B_DT2];
  assign up_d1l_op   = up_q[B_D1L];
  assign up_ar_op    = up_q[B_AR];
  assign up_d1r_op   = up_q[B_D1R];
  assign up_d2r_op   = up_q[B_D2R];
  assign up_rr_op    = up_q[B_RR];

endmodule

// File: tb/tb_jt51_op_wr_sched.sv
// Directed bench for jt51_op_wr_sched: a table of single writes plus sequences for
// back-to-back slots, ordering, FIFO full, bad addresses and reset during a strobe.
module tb_jt51_op_wr_sched;

  localparam logic [10:0] DT1 = 11'h400, MUL = 11'h200, TL  = 11'h100, KS  = 11'h080;
  localparam logic [10:0] AMS = 11'h040, DT2 = 11'h020, D1L = 11'h010, AR  = 11'h008;
  localparam logic [10:0] D1R = 11'h004, D2R = 11'h002, RR  = 11'h001;

  logic clk = 0, rst_n = 0, cen = 1, sync = 0;
  logic [7:0] din;
  logic up_dt1_op, up_mul_op, up_tl_op, up_ks_op, up_amsen_op, up_dt2_op;
  logic up_d1l_op, up_ar_op, up_d1r_op, up_d2r_op, up_rr_op, busy, bad_addr;
`ifdef JT51_OPWR_STATS_EN
  logic [15:0] wr_cnt;
  logic [7:0]  drop_cnt;
`endif

  jt51_op_wr_sched_if ifc ();

  jt51_op_wr_sched #(.DEPTH(4), .SLOT_OFS(0)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sync(sync), .wr(ifc), .din(din),
    .up_dt1_op(up_dt1_op), .up_mul_op(up_mul_op), .up_tl_op(up_tl_op), .up_ks_op(up_ks_op),
    .up_amsen_op(up_amsen_op), .up_dt2_op(up_dt2_op), .up_d1l_op(up_d1l_op), .up_ar_op(up_ar_op),
    .up_d1r_op(up_d1r_op), .up_d2r_op(up_d2r_op), .up_rr_op(up_rr_op),
    .busy(busy), .bad_addr(bad_addr)
`ifdef JT51_OPWR_STATS_EN
    , .wr_cnt(wr_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [10:0] up_vec;
  assign up_vec = {up_dt1_op, up_mul_op, up_tl_op, up_ks_op, up_amsen_op, up_dt2_op,
                   up_d1l_op, up_ar_op, up_d1r_op, up_d2r_op, up_rr_op};

  // Reference slot counter and cycle stamp
  logic [4:0] tb_slot;
  int         cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tb_slot <= 5'd0;
    else if (cen) tb_slot <= sync ? 5'd0 : tb_slot + 5'd1;
  end
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] up;
    logic [7:0]  din;
    logic [4:0]  slot;
    int          cyc;
  } ev_t;
  ev_t evq[$];

  always @(negedge clk) begin
    if (rst_n && up_vec != '0) evq.push_back('{up: up_vec, din: din, slot: tb_slot, cyc: cyc});
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bit done = 0;
    @(negedge clk);
    ifc.wr_valid = 1'b1; ifc.wr_addr = a; ifc.wr_data = d;
    for (int i = 0; i < 200 && !done; i++) begin
      if (ifc.wr_ready) begin @(posedge clk); done = 1; end
      else @(negedge clk);
    end
    #1 ifc.wr_valid = 1'b0;
    if (!done) check("wr_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    @(negedge clk);
    check("idle_reached", busy, 0);
  endtask

  task automatic check_ev(input string name, input int idx, input logic [10:0] up,
                          input logic [7:0] d, input logic [4:0] s);
    if (evq.size() > idx) begin
      check({name, "_up"},   evq[idx].up,   up);
      check({name, "_din"},  evq[idx].din,  d);
      check({name, "_slot"}, evq[idx].slot, s);
    end else begin
      check({name, "_missing"}, evq.size(), idx + 1);
    end
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [10:0] up;
    logic [4:0]  slot;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n;
    bit done;
    vecs[0] = '{8'h45, 8'h7A, DT1 | MUL, 5'd5};
    vecs[1] = '{8'h60, 8'h12, TL,        5'd0};
    vecs[2] = '{8'h9F, 8'hC3, KS | AR,   5'd31};
    vecs[3] = '{8'hA3, 8'h5A, AMS | D1R, 5'd3};
    vecs[4] = '{8'hC8, 8'h81, DT2 | D2R, 5'd8};
    vecs[5] = '{8'hFE, 8'hE7, D1L | RR,  5'd30};

    ifc.wr_valid = 0; ifc.wr_addr = 0; ifc.wr_data = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_strobes", up_vec, 0);
    check("rst_din", din, 0);
    check("rst_busy", busy, 0);
    check("rst_bad", bad_addr, 0);
    check("rst_ready", ifc.wr_ready, 1);

    sync = 1; @(negedge clk); sync = 0;

    // Single writes, one per field pair
    foreach (vecs[k]) begin
      evq.delete();
      wr(vecs[k].addr, vecs[k].data);
      wait_idle(100);
      check($sformatf("vec%0d_count", k), evq.size(), 1);
      check_ev($sformatf("vec%0d", k), 0, vecs[k].up, vecs[k].data, vecs[k].slot);
    end
`ifdef JT51_OPWR_STATS_EN
    check("wr_cnt_after_table", wr_cnt, 6);
`endif

    // Consecutive slots 0 then 1, no bubble
    evq.delete();
    wr(8'h60, 8'h12); wr(8'h61, 8'h34);
    wait_idle(100);
    check("b2b_count", evq.size(), 2);
    check_ev("b2b_a", 0, TL, 8'h12, 5'd0);
    check_ev("b2b_b", 1, TL, 8'h34, 5'd1);
    if (evq.size() == 2) check("b2b_adjacent", evq[1].cyc - evq[0].cyc, 1);

    // Wrap 31 -> 0
    evq.delete();
    wr(8'h9F, 8'hAA); wr(8'h80, 8'h55);
    wait_idle(100);
    check("wrap_count", evq.size(), 2);
    check_ev("wrap_a", 0, KS | AR, 8'hAA, 5'd31);
    check_ev("wrap_b", 1, KS | AR, 8'h55, 5'd0);
    if (evq.size() == 2) check("wrap_adjacent", evq[1].cyc - evq[0].cyc, 1);

    // FIFO order beats slot order
    evq.delete();
    wr(8'h85, 8'h01); wr(8'h83, 8'h02);
    wait_idle(100);
    check("order_count", evq.size(), 2);
    check_ev("order_a", 0, KS | AR, 8'h01, 5'd5);
    check_ev("order_b", 1, KS | AR, 8'h02, 5'd3);

    // FIFO full while cen is held low
    evq.delete();
    @(negedge clk); cen = 0;
    wr(8'h41, 8'hA1); wr(8'h42, 8'hA2); wr(8'h43, 8'hA3); wr(8'h44, 8'hA4);
    @(negedge clk);
    check("full_ready", ifc.wr_ready, 0);
    check("full_busy", busy, 1);
    ifc.wr_valid = 1; ifc.wr_addr = 8'h45; ifc.wr_data = 8'hA5;
    repeat (3) @(negedge clk);
    check("full_hold_ready", ifc.wr_ready, 0);
    check("full_frozen", evq.size(), 0);
    cen = 1;
    done = 0; n = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (ifc.wr_ready) begin n = evq.size(); @(posedge clk); done = 1; end
      else @(negedge clk);
    end
    #1 ifc.wr_valid = 0;
    check("full_fifth_accepted", done, 1);
    check("full_pop_before_push", n >= 1, 1);
    wait_idle(100);
    check("full_count", evq.size(), 5);
    for (int i = 0; i < 5; i++)
      check_ev($sformatf("full%0d", i), i, DT1 | MUL, 8'hA1 + 8'(i), 5'(i + 1));

    // Address below 0x40
    evq.delete();
    wr(8'h20, 8'h99);
    @(negedge clk);
    check("bad_pulse", bad_addr, 1);
    @(negedge clk);
    check("bad_pulse_end", bad_addr, 0);
    check("bad_busy", busy, 0);
    repeat (40) @(negedge clk);
    check("bad_no_strobe", evq.size(), 0);
`ifdef JT51_OPWR_STATS_EN
    check("drop_cnt", drop_cnt, 1);
`endif

    // Reset while a strobe is active
    wr(8'h45, 8'h7A);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (up_vec != '0) done = 1;
    end
    check("rstapply_strobe_seen", done, 1);
    #1 rst_n = 0;
    #1;
    check("rstapply_strobes", up_vec, 0);
    check("rstapply_busy", busy, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    check("rstapply_busy_after", busy, 0);
    check("rstapply_ready", ifc.wr_ready, 1);
    check("rstapply_din", din, 0);
`ifdef JT51_OPWR_STATS_EN
    check("rstapply_wr_cnt", wr_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
